load_value_responder: RTL and testbench

Responder side of the load-value-prediction handshake driven by the hazard controller. On a load request it looks up a last-value table and returns a predicted value. It then waits for the real d-cache data, compares it with the prediction, and requests pipeline recovery on a mismatch. It sits beside the d-cache in the MEM stage; `lock` feeds the hazard controller's second-request stall.

---
 rtl/lvp_pkg.sv | 33 +++
 rtl/lvp_table.sv | 59 +++++
 rtl/load_value_responder.sv | 147 ++++++++++++++
 tb/tb_load_value_responder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/lvp_pkg.sv
// Shared types and geometry helpers for the load-value-prediction responder.
package lvp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RECOVER = 2'd2
    } lvp_state_e;

    localparam int LVP_DATA_WIDTH    = 32;
    localparam int LVP_ADDR_WIDTH    = 32;
    localparam int LVP_TABLE_ENTRIES = 16;
    localparam int LVP_CONF_BITS     = 2;

    function automatic int lvp_idx_w(input int entries);
        return $clog2(entries);
    endfunction

    // Word-aligned loads: the two byte-offset bits sit below the index.
    function automatic int lvp_tag_w(input int addr_w, input int entries);
        return addr_w - $clog2(entries) - 2;
    endfunction

    localparam int LVP_TAG_W = lvp_tag_w(LVP_ADDR_WIDTH, LVP_TABLE_ENTRIES);

    typedef struct packed {
        logic                     valid;
        logic [LVP_TAG_W-1:0]     tag;
        logic [LVP_DATA_WIDTH-1:0] value;
        logic [LVP_CONF_BITS-1:0] conf;
    } lvp_entry_t;

endpackage

// File: rtl/lvp_table.sv
// Direct-mapped last-value table: async-read lookup, one write port applying
// the confidence/value update rule, whole table cleared by reset.
module lvp_table
    import lvp_pkg::*;
#(
    parameter int  DATA_WIDTH    = LVP_DATA_WIDTH,
    parameter int  TABLE_ENTRIES = LVP_TABLE_ENTRIES,
    parameter int  IDX_W         = lvp_idx_w(LVP_TABLE_ENTRIES),
    parameter int  TAG_W         = LVP_TAG_W,
    parameter type entry_t       = lvp_entry_t
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output entry_t                o_rd_entry,
    input  logic                  i_wr_en,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic [TAG_W-1:0]      i_wr_tag,
    input  logic [DATA_WIDTH-1:0] i_wr_data
);

    entry_t r_mem [TABLE_ENTRIES];
    entry_t w_cur;
    entry_t w_next;
    logic   w_hit;

    assign o_rd_entry = r_mem[i_rd_idx];

    always_comb begin
        w_cur  = r_mem[i_wr_idx];
        w_hit  = w_cur.valid && (w_cur.tag == i_wr_tag);
        w_next = w_cur;
        if (w_hit && (w_cur.value == i_wr_data)) begin
            if (w_cur.conf != '1) begin
                w_next.conf = w_cur.conf + 1'b1;
            end
        end else if (w_hit) begin
            w_next.value = i_wr_data;
            w_next.conf  = '0;
        end else begin
            // Miss or empty slot: the new address takes over the entry.
            w_next.valid = 1'b1;
            w_next.tag   = i_wr_tag;
            w_next.value = i_wr_data;
            w_next.conf  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TABLE_ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= w_next;
        end
    end

endmodule

// File: rtl/load_value_responder.sv
// Load-value-prediction responder: predicts on request, checks against d-cache
// data, holds recover until acked. One request in flight; lock stalls the next.
module load_value_responder
    import lvp_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int TABLE_ENTRIES = 16,
    parameter int CONF_BITS     = 2,
    parameter int CONF_THRESH   = 2
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  pred_valid,
    output logic [DATA_WIDTH-1:0] pred_data,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  recover,
    input  logic                  recover_ack,
    output logic                  lock,
    output logic                  done
);

    localparam int IDX_W = lvp_idx_w(TABLE_ENTRIES);
    localparam int TAG_W = lvp_tag_w(ADDR_WIDTH, TABLE_ENTRIES);
    localparam logic [CONF_BITS-1:0] THRESH = CONF_BITS'(CONF_THRESH);

    typedef struct packed {
        logic                  valid;
        logic [TAG_W-1:0]      tag;
        logic [DATA_WIDTH-1:0] value;
        logic [CONF_BITS-1:0]  conf;
    } entry_t;

    lvp_state_e            r_state, w_state_nxt;
    logic [IDX_W-1:0]      r_idx, w_idx_nxt;
    logic [TAG_W-1:0]      r_tag, w_tag_nxt;
    logic                  r_pred_valid, w_pred_valid_nxt;
    logic [DATA_WIDTH-1:0] r_pred_data, w_pred_data_nxt;
    logic                  r_done, w_done_nxt;
    logic                  w_wr_en;
    logic                  w_predict;
    entry_t                w_lookup;
    logic [IDX_W-1:0]      w_req_idx;
    logic [TAG_W-1:0]      w_req_tag;
    logic [1:0]            w_unused_byte_ofs;

    assign w_req_idx         = req_addr[IDX_W+1:2];
    assign w_req_tag         = req_addr[ADDR_WIDTH-1:IDX_W+2];
    assign w_unused_byte_ofs = req_addr[1:0];

    lvp_table #(
        .DATA_WIDTH   (DATA_WIDTH),
        .TABLE_ENTRIES(TABLE_ENTRIES),
        .IDX_W        (IDX_W),
        .TAG_W        (TAG_W),
        .entry_t      (entry_t)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .i_rd_idx  (w_req_idx),
        .o_rd_entry(w_lookup),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (r_idx),
        .i_wr_tag  (r_tag),
        .i_wr_data (mem_data)
    );

    assign w_predict = w_lookup.valid && (w_lookup.tag == w_req_tag) &&
                       (w_lookup.conf >= THRESH);

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_tag_nxt        = r_tag;
        w_pred_valid_nxt = r_pred_valid;
        w_pred_data_nxt  = r_pred_data;
        w_done_nxt       = 1'b0;
        w_wr_en          = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_nxt      = WAIT;
                    w_idx_nxt        = w_req_idx;
                    w_tag_nxt        = w_req_tag;
                    w_pred_valid_nxt = w_predict;
                    w_pred_data_nxt  = w_predict ? w_lookup.value : '0;
                end
            end
            WAIT: begin
                if (mem_valid) begin
                    w_wr_en = 1'b1;
                    if (r_pred_valid && (mem_data != r_pred_data)) begin
                        w_state_nxt = RECOVER;
                    end else begin
                        w_state_nxt      = IDLE;
                        w_done_nxt       = 1'b1;
                        w_pred_valid_nxt = 1'b0;
                        w_pred_data_nxt  = '0;
                    end
                end
            end
            RECOVER: begin
                if (recover_ack) begin
                    w_state_nxt      = IDLE;
                    w_done_nxt       = 1'b1;
                    w_pred_valid_nxt = 1'b0;
                    w_pred_data_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt      = IDLE;
                w_pred_valid_nxt = 1'b0;
                w_pred_data_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_tag        <= '0;
            r_pred_valid <= 1'b0;
            r_pred_data  <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_tag        <= w_tag_nxt;
            r_pred_valid <= w_pred_valid_nxt;
            r_pred_data  <= w_pred_data_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign lock       = (r_state != IDLE);
    assign recover    = (r_state == RECOVER);
    assign pred_valid = r_pred_valid;
    assign pred_data  = r_pred_data;
    assign done       = r_done;

endmodule

// File: tb/tb_load_value_responder.sv
// Directed bench for load_value_responder: inputs driven and outputs checked on
// the falling edge, expected values hand-derived from the table update rules.
module tb_load_value_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        pred_valid;
    logic [31:0] pred_data;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        recover;
    logic        recover_ack;
    logic        lock;
    logic        done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_value_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .pred_valid (pred_valid),
        .pred_data  (pred_data),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data),
        .recover    (recover),
        .recover_ack(recover_ack),
        .lock       (lock),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge with the DUT idle; returns on the falling edge
    // of the done cycle so the next call issues a back-to-back request.
    task automatic load(input logic [31:0] addr, input logic [31:0] data,
                        input logic exp_pv, input logic [31:0] exp_pd,
                        input logic exp_rec, input int delay, input logic noise);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge clk);
        // 0x300 aliases index 0; accepting it here would corrupt state.
        req_valid = noise;
        req_addr  = 32'h0000_0300;
        chk("lock_wait", {31'd0, lock}, 32'd1);
        chk("req_ready_wait", {31'd0, req_ready}, 32'd0);
        chk("pred_valid", {31'd0, pred_valid}, {31'd0, exp_pv});
        chk("pred_data", pred_data, exp_pd);
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            chk("pred_hold", pred_data, exp_pd);
            chk("done_wait", {31'd0, done}, 32'd0);
        end
        mem_valid = 1'b1;
        mem_data  = data;
        @(negedge clk);
        mem_valid = 1'b0;
        if (exp_rec) begin
            chk("recover_m1", {31'd0, recover}, 32'd1);
            chk("done_in_recover", {31'd0, done}, 32'd0);
            @(negedge clk);
            chk("recover_held", {31'd0, recover}, 32'd1);
            chk("lock_recover", {31'd0, lock}, 32'd1);
            recover_ack = 1'b1;
            @(negedge clk);
            recover_ack = 1'b0;
        end
        req_valid = 1'b0;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("recover_clear", {31'd0, recover}, 32'd0);
        chk("lock_clear", {31'd0, lock}, 32'd0);
        chk("pred_valid_clear", {31'd0, pred_valid}, 32'd0);
        chk("pred_data_clear", pred_data, 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_addr    = '0;
        mem_valid   = 1'b0;
        mem_data    = '0;
        recover_ack = 1'b0;

        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
        chk("rst_pred_data", pred_data, 32'd0);
        chk("rst_recover", {31'd0, recover}, 32'd0);
        chk("rst_lock", {31'd0, lock}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Training: conf is 0,1,2 when loads 2,3,4 look up, so load 4 predicts.
        load(32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        load(32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1, 1'b0);
        load(32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        load(32'h100, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b0, 2, 1'b0);

        // Mispredict, with stray requests during WAIT and RECOVER.
        load(32'h100, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b1, 0, 1'b1);
        load(32'h100, 32'h12345678, 1'b0, 32'h0, 1'b0, 0, 1'b0);

        // Aliasing: 0x140 shares index 0 with 0x100 and steals the entry.
        load(32'h100, 32'h12345678, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        load(32'h100, 32'h12345678, 1'b1, 32'h12345678, 1'b0, 0, 1'b0);
        load(32'h140, 32'hAAAA5555, 1'b0, 32'h0, 1'b0, 0, 1'b0);
        load(32'h100, 32'h12345678, 1'b0, 32'h0, 1'b0, 0, 1'b0);

        // Saturation: a wrapping counter would drop the prediction after load 4.
        for (int i = 0; i < 10; i++) begin
            load(32'h204, 32'hCAFEF00D, (i >= 3), (i >= 3) ? 32'hCAFEF00D : 32'h0,
                 1'b0, i % 3, (i == 5));
        end

        // mem_valid and recover_ack while idle must be ignored.
        @(negedge clk);
        mem_valid   = 1'b1;
        mem_data    = 32'h11111111;
        recover_ack = 1'b1;
        @(negedge clk);
        mem_valid   = 1'b0;
        recover_ack = 1'b0;
        chk("idle_ignore_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_ignore_lock", {31'd0, lock}, 32'd0);
        chk("idle_ignore_done", {31'd0, done}, 32'd0);
        chk("idle_ignore_recover", {31'd0, recover}, 32'd0);
        load(32'h204, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b0, 0, 1'b0);

        // Reset in the middle of WAIT abandons the transaction and the table.
        req_valid = 1'b1;
        req_addr  = 32'h204;
        @(negedge clk);
        req_valid = 1'b0;
        chk("pre_rst_lock", {31'd0, lock}, 32'd1);
        chk("pre_rst_pred", pred_data, 32'hCAFEF00D);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_lock", {31'd0, lock}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_pred_valid", {31'd0, pred_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_done", {31'd0, done}, 32'd0);
        load(32'h204, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, 0, 1'b0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
